// File: rtl/cnn_kernel_bias_loader.sv
// ---------------------------------------------------------------------------
// cnn_kernel_bias_loader
//
// Write-side controller for the CNN kernel/bias BRAM bank array. Accepts a
// valid/ready stream of kernel/bias words and spreads them round-robin across
// KERNEL_BRAM_NUM banks: word k goes to bank (k mod N) at address (k / N).
// Writes are registered (one cycle after the accepting edge). Loading waits
// for the BRAM reset-busy flag to clear and stalls whenever it is raised.
//
// Ports:
//   i_clock             clock for all logic
//   i_reset             asynchronous, active-high reset
//   i_start             one-cycle start request, sampled only in IDLE
//   i_kernel_bias_size  total words to load, sampled with i_start
//   i_bram_reset_busy   OR of all bank reset-busy flags
//   i_valid / i_data    input word stream
//   o_ready             loader accepts a word this cycle (combinational)
//   o_wenable           per-bank write enable
//   o_waddress          per-bank write address
//   o_bram_data         per-bank write data
//   o_busy              high while waiting for BRAM reset or loading
//   o_done              one-cycle pulse after the load completes
//   o_error             one-cycle pulse when a start is rejected (size too big)
//
// State table:
//   state    | meaning
//   IDLE     | waiting for i_start
//   WAIT_RST | size accepted, waiting for BRAM reset-busy to clear
//   LOAD     | accepting words and issuing bank writes
//   DONE     | last write issued; pulses o_done next cycle, back to IDLE
// ---------------------------------------------------------------------------
module cnn_kernel_bias_loader #(
    parameter int DATA_WIDTH                     = 32,
    parameter int KERNEL_BRAM_NUM                = 4,
    parameter int KERNEL_BIAS_BRAM_ADDRESS_WIDTH = 4,
    parameter int KERNEL_BIAS_WIDTH              = 8
) (
    input  logic                                                     i_clock,
    input  logic                                                     i_reset,
    input  logic                                                     i_start,
    input  logic [KERNEL_BIAS_WIDTH-1:0]                             i_kernel_bias_size,
    input  logic                                                     i_bram_reset_busy,
    input  logic                                                     i_valid,
    input  logic [DATA_WIDTH-1:0]                                    i_data,
    output logic                                                     o_ready,
    output logic [KERNEL_BRAM_NUM-1:0]                               o_wenable,
    output logic [KERNEL_BRAM_NUM-1:0][KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] o_waddress,
    output logic [KERNEL_BRAM_NUM-1:0][DATA_WIDTH-1:0]               o_bram_data,
    output logic                                                     o_busy,
    output logic                                                     o_done,
    output logic                                                     o_error
);

    localparam int BANK_SHIFT = $clog2(KERNEL_BRAM_NUM);
    localparam int unsigned CAPACITY =
        KERNEL_BRAM_NUM << KERNEL_BIAS_BRAM_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RST = 2'd1,
        S_LOAD     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                                state;
    state_t                                state_next;
    logic [KERNEL_BIAS_WIDTH-1:0]          counter;
    logic [KERNEL_BIAS_WIDTH-1:0]          size_q;

    logic                                  accept;
    logic                                  last_word;
    logic                                  size_zero;
    logic                                  size_oversize;
    logic                                  start_ok;
    logic                                  start_reject;
    logic [BANK_SHIFT-1:0]                 wr_bank;
    logic [KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] wr_addr;

    assign o_ready   = (state == S_LOAD) && !i_bram_reset_busy;
    assign accept    = i_valid && o_ready;
    assign last_word = (counter == (size_q - KERNEL_BIAS_WIDTH'(1)));

    assign size_zero     = (i_kernel_bias_size == '0);
    // Compare at 32 bits so capacities wider than the size port still work.
    assign size_oversize = 32'(i_kernel_bias_size) > CAPACITY;
    assign start_ok      = (state == S_IDLE) && i_start && !size_zero && !size_oversize;
    assign start_reject  = (state == S_IDLE) && i_start && size_oversize;

    // Round-robin interleave: low counter bits pick the bank, the rest the row.
    assign wr_bank = counter[BANK_SHIFT-1:0];
    assign wr_addr = KERNEL_BIAS_BRAM_ADDRESS_WIDTH'(counter >> BANK_SHIFT);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (size_zero) begin
                        state_next = S_DONE;
                    end else if (!size_oversize) begin
                        state_next = S_WAIT_RST;
                    end
                end
            end
            S_WAIT_RST: begin
                if (!i_bram_reset_busy) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && last_word) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Word counter and latched size
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            counter <= '0;
            size_q  <= '0;
        end else begin
            if (start_ok) begin
                counter <= '0;
                size_q  <= i_kernel_bias_size;
            end else if (accept) begin
                counter <= counter + KERNEL_BIAS_WIDTH'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bank write port. Only the targeted bank changes; the others keep their
    // last address/data so idle banks do not toggle.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_wenable   <= '0;
            o_waddress  <= '0;
            o_bram_data <= '0;
        end else begin
            o_wenable <= '0;
            if (accept) begin
                o_wenable[wr_bank]   <= 1'b1;
                o_waddress[wr_bank]  <= wr_addr;
                o_bram_data[wr_bank] <= i_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status outputs. o_busy follows the state it will be in after this edge
    // so that it lines up with the state register rather than lagging it.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_error <= 1'b0;
        end else begin
            o_busy  <= (state_next == S_WAIT_RST) || (state_next == S_LOAD);
            o_done  <= (state == S_DONE);
            o_error <= start_reject;
        end
    end

endmodule

// File: doc/cnn_kernel_bias_loader.md
Name: cnn_kernel_bias_loader

Overview:
Write-side controller for the CNN kernel/bias BRAM bank array (KERNEL_BRAM_NUM dual-port BRAMs, one per kernel lane). It accepts a valid/ready stream of packed kernel/bias words and interleaves them round-robin across the banks, generating per-bank write enables and addresses. It gates loading on the BRAM reset-busy flag and reports busy, done and size errors to the layer sequencer.

Parameters:
DATA_WIDTH, 32, width of one kernel/bias word (BRAM data width).
KERNEL_BRAM_NUM, 4, number of banks; must be a power of two >= 2.
KERNEL_BIAS_BRAM_ADDRESS_WIDTH, 4, per-bank address width; bank depth = 2**KERNEL_BIAS_BRAM_ADDRESS_WIDTH.
KERNEL_BIAS_WIDTH, 8, width of the word-count input and the internal word counter.

Ports:
i_clock  in  1  single clock for all logic.
i_reset  in  1  asynchronous, active-high reset.
i_start  in  1  one-cycle start request; sampled only in IDLE.
i_kernel_bias_size  in  KERNEL_BIAS_WIDTH  total words to load; sampled with i_start.
i_bram_reset_busy  in  1  OR of all bank rsta/rstb busy flags.
i_valid  in  1  input word valid.
i_data  in  DATA_WIDTH  input word.
o_ready  out  1  loader can accept a word this cycle.
o_wenable  out  [0:0] x KERNEL_BRAM_NUM  per-bank write enable.
o_waddress  out  KERNEL_BIAS_BRAM_ADDRESS_WIDTH x KERNEL_BRAM_NUM  per-bank write address.
o_bram_data  out  DATA_WIDTH x KERNEL_BRAM_NUM  per-bank write data.
o_busy  out  1  high in WAIT_RST and LOAD.
o_done  out  1  one-cycle pulse when the load completes.
o_error  out  1  one-cycle pulse when the start request is rejected.

Behaviour:
- Reset: state=IDLE; counter=0; stored size=0; all o_wenable=0, o_waddress=0, o_bram_data=0; o_busy=0, o_done=0, o_error=0. o_ready is 0 while reset is asserted.
- States: IDLE, WAIT_RST, LOAD, DONE.
- IDLE + i_start:
  - size==0: go to DONE (o_done pulses; no writes).
  - size > KERNEL_BRAM_NUM*2**KERNEL_BIAS_BRAM_ADDRESS_WIDTH: o_error=1 for the next cycle; stay in IDLE; no writes.
  - Otherwise: latch the size, clear the counter, go to WAIT_RST.
- i_start outside IDLE is ignored.
- WAIT_RST -> LOAD on the first cycle with i_bram_reset_busy==0. If busy is already low, the controller still spends one cycle in WAIT_RST.
- o_ready is combinational: (state==LOAD) && !i_bram_reset_busy.
- Accept condition: i_valid && o_ready.
- Accepted word k, where k is the counter value:
  - Bank b = k mod KERNEL_BRAM_NUM; address = k / KERNEL_BRAM_NUM (shift by log2(KERNEL_BRAM_NUM)).
  - Next cycle (registered, latency 1): o_wenable[b]=1, o_waddress[b]=address, o_bram_data[b]=i_data.
  - Other banks: wenable=0, address/data hold their previous values.
- Counter increments on every accept.
- Accepting word size-1 moves the state to DONE. That last write is issued in the same cycle that DONE is entered.
- i_bram_reset_busy rising during LOAD deasserts o_ready immediately; the load stalls with no lost or duplicated words and resumes when busy clears.
- DONE: o_done=1 for exactly one cycle, o_wenable all 0, then go to IDLE.
- o_busy is registered from the state (1 in WAIT_RST/LOAD).
- A word presented while o_ready=0 is not consumed; the source must hold i_data until it is accepted.
- Asynchronous reset mid-load:
  - Immediately clears all state and deasserts every o_wenable.
  - Partially written BRAM contents are undefined.
  - The sequencer must restart the load.
- Counter width is KERNEL_BIAS_WIDTH; the counter never wraps because of the size check.

Test Plan:
1. Reset, start with size=6, stream 0xA0..0xA5 with i_valid held high and no busy. Required: one-cycle write latency. Writes are b0@0=A0, b1@0=A1, b2@0=A2, b3@0=A3, b0@1=A4, b1@1=A5. o_done pulses once, one cycle after the A5 write.
2. Start with size=0. Required: no wenable, o_done pulse, return to IDLE; o_busy=1 for 0 cycles.
3. Start with size=65 (capacity 64). Required: o_error pulses one cycle; state stays IDLE; no writes. A following start with size=64 succeeds and the last write is b3@15.
4. Hold i_bram_reset_busy=1 for 5 cycles after start. Required: o_ready=0 and o_busy=1 throughout; loading begins the cycle after busy drops.
5. Size=8; raise busy for 3 cycles after word 3; toggle i_valid randomly. Required: exactly 8 writes, in order and with correct bank/address, and no duplicates.
6. Assert i_reset after word 2 of a size=8 load. Required: all outputs return to reset values asynchronously. A new start with size=4 then writes b0..b3 at address 0.
